// File: rtl/cav14_chase_rx.sv
// rtl/cav14_chase_rx.sv - CAV14 chase receiver: LEAD count from a valid/ready leader, FOLLOW count that never overtakes it.
// Optional CHASE_ASSERT_EN adds the safety assertions and a prop_neg output.
module cav14_chase_rx #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   CNT_MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_valid,
    output logic         inc_ready,
    input  logic         take,
    output logic         take_ack,
    output logic [W-1:0] lead,
    output logic [W-1:0] follow,
    output logic         sat,
`ifdef CHASE_ASSERT_EN
    output logic         prop_neg,
`endif
    output logic         prop
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SAT  = 2'd1,
        WRAP = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       state, state_nxt;
    logic [W-1:0] lead_nxt, follow_nxt;
    logic         ack_nxt;
    logic         inc_accept;
    logic         grant;
    logic [W-1:0] lead_inc;

    // inc_ready depends only on registered state, never on inc_valid
    assign inc_ready  = (state == RUN) && (lead != CNT_MAX);
    assign inc_accept = inc_valid && inc_ready;
    assign grant      = take && (state != WRAP) && (follow < lead);
    assign lead_inc   = lead + ONE;

    always_comb begin
        state_nxt  = state;
        lead_nxt   = lead;
        follow_nxt = follow;
        ack_nxt    = grant;
        if (grant) begin
            follow_nxt = follow + ONE;
        end
        case (state)
            RUN: begin
                if (inc_accept) begin
                    lead_nxt = lead_inc;
                    if (lead_inc == CNT_MAX) begin
                        state_nxt = SAT;
                    end
                end
            end
            SAT: begin
                if (follow == CNT_MAX) begin
                    state_nxt = WRAP;
                end
            end
            WRAP: begin
                lead_nxt   = '0;
                follow_nxt = '0;
                state_nxt  = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            lead     <= '0;
            follow   <= '0;
            take_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            lead     <= lead_nxt;
            follow   <= follow_nxt;
            take_ack <= ack_nxt;
        end
    end

    assign sat  = (state == SAT);
    assign prop = !(follow > lead);

`ifdef CHASE_ASSERT_EN
    assign prop_neg = !prop;

    a_follow_le_lead: assert property (@(posedge clk) disable iff (rst) prop);
    a_wrap_equal:     assert property (@(posedge clk) disable iff (rst) (!(state == WRAP) || (lead == follow)));
`endif

endmodule

// File: tb/tb_cav14_chase_rx.sv
// tb/tb_cav14_chase_rx.sv - directed table plus hand sequences and a reference model for cav14_chase_rx.
module tb_cav14_chase_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inc_valid = 1'b0;
    logic       inc_ready;
    logic       take = 1'b0;
    logic       take_ack;
    logic [3:0] lead;
    logic [3:0] follow;
    logic       sat;
    logic       prop;

    int n_vec = 0;
    int n_err = 0;

    cav14_chase_rx dut (
        .clk       (clk),
        .rst       (rst),
        .inc_valid (inc_valid),
        .inc_ready (inc_ready),
        .take      (take),
        .take_ack  (take_ack),
        .lead      (lead),
        .follow    (follow),
        .sat       (sat),
        .prop      (prop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic       tk;
        logic [3:0] lead;
        logic [3:0] follow;
        logic       ack;
        logic       sat;
        logic       rdy;
    } vec_t;

    vec_t vecs[17];

    // reference model state (0=RUN, 1=SAT, 2=WRAP)
    logic [3:0] m_lead = 4'd0, m_follow = 4'd0;
    logic [1:0] m_state = 2'd0;
    logic       m_ack = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic iv, input logic tk);
        rst = r;
        inc_valid = iv;
        take = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int l, input int f, input int a, input int s, input int r);
        check({tag, ".lead"}, lead, l);
        check({tag, ".follow"}, follow, f);
        check({tag, ".take_ack"}, take_ack, a);
        check({tag, ".sat"}, sat, s);
        check({tag, ".inc_ready"}, inc_ready, r);
    endtask

    task automatic model_step(input logic r, input logic iv, input logic tk);
        logic       rdy, g;
        logic [3:0] nl, nf;
        logic [1:0] ns;
        rdy = (m_state == 2'd0) && (m_lead != 4'hF);
        g   = tk && (m_state != 2'd2) && (m_follow < m_lead);
        nl = m_lead; nf = m_follow; ns = m_state;
        if (g) nf = m_follow + 4'd1;
        if (m_state == 2'd0 && iv && rdy) begin
            nl = m_lead + 4'd1;
            if (nl == 4'hF) ns = 2'd1;
        end else if (m_state == 2'd1 && m_follow == 4'hF) begin
            ns = 2'd2;
        end else if (m_state == 2'd2) begin
            nl = 4'd0; nf = 4'd0; ns = 2'd0;
        end
        if (r) begin
            nl = 4'd0; nf = 4'd0; ns = 2'd0; g = 1'b0;
        end
        m_lead = nl; m_follow = nf; m_state = ns; m_ack = g;
    endtask

    initial begin
        //               rst iv tk  lead follow ack sat rdy
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd3, 4'd1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 4'd3, 4'd1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'd4, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 4'd5, 4'd2, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 4'd6, 4'd3, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 4'd6, 4'd3, 1'b0, 1'b0, 1'b1};

        #1;
        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].rst, vecs[i].iv, vecs[i].tk);
            check_all($sformatf("vec%0d", i), vecs[i].lead, vecs[i].follow,
                      vecs[i].ack, vecs[i].sat, vecs[i].rdy);
        end

        // fill to saturation, then a refused 16th increment
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            check("fill.lead", lead, i);
        end
        check_all("sat_entry", 15, 0, 0, 1, 0);
        cycle(1'b0, 1'b1, 1'b0);
        check_all("inc16_refused", 15, 0, 0, 1, 0);

        // drain in SAT, one WRAP cycle ignoring take, back to RUN
        for (int i = 1; i <= 15; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            check("drain.follow", follow, i);
            check("drain.ack", take_ack, 1);
        end
        check_all("drained", 15, 15, 1, 1, 0);
        cycle(1'b0, 1'b0, 1'b0);
        check_all("wrap_cycle", 15, 15, 0, 0, 0);
        cycle(1'b0, 1'b1, 1'b1);
        check_all("after_wrap", 0, 0, 0, 0, 1);

        // reset in SAT with follow=9
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1);
        check_all("pre_rst_sat", 15, 9, 1, 1, 0);
        cycle(1'b1, 1'b1, 1'b1);
        check_all("rst_in_sat", 0, 0, 0, 0, 1);

        // random run against the reference model
        cycle(1'b1, 1'b0, 1'b0);
        m_lead = 4'd0; m_follow = 4'd0; m_state = 2'd0; m_ack = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            logic r, iv, tk;
            r  = ($urandom_range(0, 499) == 0);
            iv = ($urandom_range(0, 3) != 0);
            tk = ($urandom_range(0, 2) != 0);
            model_step(r, iv, tk);
            cycle(r, iv, tk);
            check("rand.prop", prop, 1);
            check("rand.lead", lead, m_lead);
            check("rand.follow", follow, m_follow);
            check("rand.ack", take_ack, m_ack);
            check("rand.sat", sat, (m_state == 2'd1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
